// File: rtl/br_pkg.sv
// Shared definitions for the branch decide unit: branch-type encodings,
// 2-bit predictor constants and the saturating predictor update helper.
package br_pkg;

    localparam logic [2:0] BR_BEQ    = 3'd0;
    localparam logic [2:0] BR_BNE    = 3'd1;
    localparam logic [2:0] BR_BLTZ   = 3'd2;
    localparam logic [2:0] BR_BGEZ   = 3'd3;
    localparam logic [2:0] BR_BLEZ   = 3'd4;
    localparam logic [2:0] BR_BGTZ   = 3'd5;
    localparam logic [2:0] BR_ALWAYS = 3'd6;
    localparam logic [2:0] BR_NEVER  = 3'd7;

    localparam logic [1:0] PRED_RESET = 2'b01;  // weakly not-taken
    localparam logic [1:0] PRED_MAX   = 2'b11;
    localparam logic [1:0] PRED_MIN   = 2'b00;

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic logic [1:0] pred_next(input logic [1:0] cur, input logic taken);
        if (taken)
            return (cur == PRED_MAX) ? PRED_MAX : cur + 2'd1;
        else
            return (cur == PRED_MIN) ? PRED_MIN : cur - 2'd1;
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator.
// Ports: br_type (condition select), zero/sign (ALU flags) -> cond.
module br_cond_eval
    import br_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       zero,
    input  logic       sign,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (br_type)
            BR_BEQ:    cond = zero;
            BR_BNE:    cond = !zero;
            BR_BLTZ:   cond = sign;
            BR_BGEZ:   cond = !sign;
            BR_BLEZ:   cond = sign | zero;
            BR_BGTZ:   cond = !sign & !zero;
            BR_ALWAYS: cond = 1'b1;
            BR_NEVER:  cond = 1'b0;
            default:   cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_decide_unit.sv
// Branch decision unit: evaluates the branch condition, registers the
// PC-source decision (1-cycle latency), maintains a direct-mapped table of
// 2-bit saturating predictors read by fetch, and flags mispredicts.
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid, branch, br_type   resolving instruction and its condition
//   zero, sign                  ALU flags
//   pc_idx, pred_in             table index / fetch prediction of the branch
//   pred_idx -> pred_taken      combinational fetch-side table lookup
//   out_valid, pc_src, mispredict  registered decision
//   clr                         synchronous clear of statistics
//   br_cnt, taken_cnt, miss_cnt saturating statistics counters
module branch_decide_unit
    import br_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             branch,
    input  logic [2:0]       br_type,
    input  logic             zero,
    input  logic             sign,
    input  logic [IDX_W-1:0] pc_idx,
    input  logic             pred_in,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_taken,
    output logic             out_valid,
    output logic             pc_src,
    output logic             mispredict,
    input  logic             clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       cond;
    logic       br_act;
    logic       take;
    logic       miss;
    logic [1:0] pred_tbl [DEPTH];

    br_cond_eval u_cond (
        .br_type (br_type),
        .zero    (zero),
        .sign    (sign),
        .cond    (cond)
    );

    assign br_act = in_valid & branch;
    assign take   = br_act & cond;
    assign miss   = br_act & (cond != pred_in);

    // Fetch sees the pre-edge entry, so a same-cycle update is not forwarded.
    assign pred_taken = pred_tbl[pred_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            pc_src     <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            pc_src     <= take;
            mispredict <= miss;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                pred_tbl[i] <= PRED_RESET;
        end else if (br_act) begin
            pred_tbl[pc_idx] <= pred_next(pred_tbl[pc_idx], cond);
        end
    end

    // Counters stick at all-ones; clr has priority over any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            miss_cnt  <= '0;
        end else if (clr) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            miss_cnt  <= '0;
        end else if (br_act) begin
            if (br_cnt != '1)
                br_cnt <= br_cnt + CNT_ONE;
            if (cond && taken_cnt != '1)
                taken_cnt <= taken_cnt + CNT_ONE;
            if (miss && miss_cnt != '1)
                miss_cnt <= miss_cnt + CNT_ONE;
        end
    end

endmodule

// File: doc/branch_decide_unit.md
Name: branch_decide_unit

Overview:
Parametrised successor to the datapath's single Branch&&Zero gate. It evaluates eight branch conditions from ALU flags and registers the PC-source decision with one-cycle latency. It also keeps a direct-mapped table of 2-bit saturating predictors, which fetch reads, and flags mispredicts. Saturating statistics counters support debug. It sits between the ALU/control outputs and the PC-select mux.

Parameters:
IDX_W, 4, predictor index width; table depth = 2**IDX_W entries.
CNT_W, 16, width of each statistics counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  resolving instruction present this cycle.
branch  input  1  control-unit branch flag (successor of Branch).
br_type  input  3  condition select, encoding below.
zero  input  1  ALU result == 0 (successor of Zero).
sign  input  1  ALU result MSB (negative).
pc_idx  input  IDX_W  PC[IDX_W+1:2] of the resolving branch.
pred_in  input  1  prediction made at fetch for this branch.
pred_idx  input  IDX_W  fetch-stage lookup index.
pred_taken  output  1  combinational: table[pred_idx][1].
out_valid  output  1  registered in_valid.
pc_src  output  1  registered taken decision.
mispredict  output  1  registered (taken != pred_in) for branches.
clr  input  1  synchronous clear of statistics counters.
br_cnt  output  CNT_W  resolved branches.
taken_cnt  output  CNT_W  taken branches.
miss_cnt  output  CNT_W  mispredicts.

Behaviour:
- Condition encoding: 0 BEQ=zero; 1 BNE=!zero; 2 BLTZ=sign; 3 BGEZ=!sign; 4 BLEZ=sign|zero; 5 BGTZ=!sign&!zero; 6 ALWAYS=1; 7 NEVER=0.
- cond is pure combinational. br_act = in_valid & branch. take = br_act & cond.
- Latency is 1 cycle. On each edge: out_valid<=in_valid; pc_src<=take; mispredict<=br_act&(cond!=pred_in).
- Non-branch valid (in_valid=1, branch=0): out_valid=1, pc_src=0, mispredict=0. No table update and no counter change.
- in_valid=0: out_valid=0, pc_src=0, mispredict=0. Flag inputs are ignored (don't-care, including X).
- Predictor table: 2**IDX_W entries of 2 bits. On br_act, entry[pc_idx] increments on cond and decrements on !cond. It saturates at 3 and at 0.
- pred_taken reads the pre-edge table value. If pred_idx==pc_idx in an update cycle, the old value is returned (read-before-write).
- Statistics on br_act: br_cnt+1; taken_cnt+1 if cond; miss_cnt+1 if cond!=pred_in. Each counter saturates at all-ones and does not wrap.
- clr zeroes all three counters next edge. clr wins over a simultaneous increment. clr does not touch the table or the pipeline outputs.
- Reset (async, any time):
  - out_valid, pc_src and mispredict go to 0.
  - All table entries go to 2'b01 (weakly not-taken).
  - All counters go to 0.
  - An in-flight decision is dropped, with no output pulse after reset release.
- First edge after reset deassertion behaves normally.

Decomposition:
- Package br_pkg:
  - br_type localparams BR_BEQ..BR_NEVER (3'd0..3'd7).
  - PRED_RESET=2'b01, PRED_MAX=2'b11, PRED_MIN=2'b00.
- Sub-module br_cond_eval: combinational (br_type, zero, sign) -> cond. It is reused by the future pipelined datapath's early-branch stage.
- Table, output registers and counters stay in the top module.

Test Plan:
- BEQ/BNE sweep: in_valid=1, branch=1; type 0, zero=1 then type 1, zero=1 -> next cycle pc_src=1 then 0; out_valid=1 both cycles.
- All 8 types x 4 (zero,sign) combos with pred_in=0 -> pc_src matches the encoding table; mispredict==pc_src; br_cnt=32 at end.
- Predictor saturation: 4 taken BEQ at pc_idx=5 -> table[5]: 01→10→11→11→11, pred_taken(pred_idx=5)=1. Then 4 not-taken -> 10→01→00→00, pred_taken=0.
- Read-before-write: table[3]=01, taken branch at pc_idx=3 with pred_idx=3 same cycle -> pred_taken=0 that cycle, 1 next cycle.
- Counter saturation/clr (CNT_W=2): 5 taken branches -> br_cnt=taken_cnt=3. Assert clr with a 6th branch -> all counters 0.
- Async reset mid-operation: taken branch issued, rst pulsed before the edge -> pc_src/out_valid stay 0, table[idx]=01, counters 0.
- Non-branch: in_valid=1, branch=0, zero=1, type 0 -> pc_src=0, out_valid=1, br_cnt unchanged.
